// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch front-end.
// Issues word-aligned fetches at the current PC, buffers in-order responses
// tagged with their PC in a small FIFO, and hands them to decode over a
// valid/ready handshake. A redirect re-steers the PC, flushes the FIFO and
// discards every response still in flight.
// Optional build macro IFETCH_PERF_EN adds perf_fetch_cnt / perf_drop_cnt.
module ifetch_unit #(
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_drop_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_SUM = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

  // Instruction buffer storage
  logic [31:0]       instr_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] pc_mem    [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  fifo_count;

  // Fetch bookkeeping
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  drop_cnt;
  logic [ADDR_W-1:0] rsp_pc;

  // Combinational control
  logic [CNT_W:0]    credit_sum;
  logic [ADDR_W-1:0] redirect_tgt;
  logic              req_fire;
  logic              rsp_live;
  logic              rsp_drop;
  logic              push;
  logic              pop;

  assign credit_sum   = {1'b0, fifo_count} + {1'b0, outstanding};
  assign redirect_tgt = redirect_pc & WORD_MASK;

  // Request issue and next-PC selection (redirect > accepted fetch > hold)
  always_comb begin
    imem_addr      = pc & WORD_MASK;
    imem_req_valid = rst_n && !redirect_valid && (credit_sum < DEPTH_SUM);
    req_fire       = imem_req_valid && imem_req_ready;
    if (redirect_valid) begin
      pc_next = redirect_tgt;
    end else if (req_fire) begin
      pc_next = pc + WORD_STEP;
    end else begin
      pc_next = pc;
    end
  end

  // Response classification and decode handshake
  always_comb begin
    rsp_live = imem_rsp_valid && (outstanding != '0);
    rsp_drop = rsp_live && (redirect_valid || (drop_cnt != '0));
    push     = rsp_live && !rsp_drop;
    if_valid = (fifo_count != '0) && !redirect_valid;
    pop      = if_valid && if_ready;
    if_instr = instr_mem[rd_ptr];
    if_pc    = pc_mem[rd_ptr];
  end

  // Buffer storage: write the tagged response at the tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (push) begin
      instr_mem[wr_ptr] <= imem_rsp_data;
      pc_mem[wr_ptr]    <= rsp_pc;
    end
  end

  // Buffer pointers and occupancy; a redirect empties the buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else if (redirect_valid) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // In-flight tracking, drop accounting and response PC tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
      drop_cnt    <= '0;
      rsp_pc      <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(rsp_live);
      if (redirect_valid) begin
        // Everything still in flight, minus the response landing now, is stale.
        drop_cnt <= outstanding - CNT_W'(rsp_live);
        rsp_pc   <= redirect_tgt;
      end else begin
        if (rsp_drop) drop_cnt <= drop_cnt - CNT_W'(1);
        if (push)     rsp_pc   <= rsp_pc + WORD_STEP;
      end
    end
  end

`ifdef IFETCH_PERF_EN
  // Performance counters: decode transfers and discarded/flushed instructions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if (pop) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      perf_drop_cnt <= perf_drop_cnt + 32'(rsp_drop)
                     + (redirect_valid ? 32'(fifo_count) : '0);
    end
  end
`endif

endmodule
